mem_line_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_line_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_line_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the line-burst memory front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

  // Width of one memory word and of each word slot inside a line.
  localparam int WORD_W = 32;

  // Default log2 of words per line.
  localparam int DEF_LINE_ADDR_LEN = 3;

  // Controller state encoding.
  localparam int STATE_W = 3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_XFER = 3'd2;
  localparam logic [2:0] ST_TAIL = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Words per line derived from the line offset width.
  function automatic int line_size(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

endpackage

// File: rtl/mem_line_ctrl.sv
// Whole-line read/write front end for a single-port word memory with 1-cycle registered reads.
// Latency: request sampled in cycle 0 -> gnt in cycle LATENCY+LINE_SIZE+2 (read) / +1 (write).
// Backpressure: one op at a time; requests are level-held and ignored outside IDLE until gnt.
module mem_line_ctrl
  import mem_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int ADDR_LEN      = 11,
  parameter int LATENCY       = 4,
  localparam int LINE_SIZE    = line_size(LINE_ADDR_LEN),
  localparam int LINE_W       = WORD_W * LINE_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_req,
  input  logic                              wr_req,
  input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0] line_addr,
  input  logic [LINE_W-1:0]                 wr_line,
  output logic [LINE_W-1:0]                 rd_line,
  output logic                              gnt,
  output logic [ADDR_LEN-1:0]               mem_addr,
  output logic                              mem_wr_req,
  output logic [WORD_W-1:0]                 mem_wr_data,
  input  logic [WORD_W-1:0]                 mem_rd_data
);

  localparam int LINE_BITS = ADDR_LEN - LINE_ADDR_LEN;
  // Sized so LATENCY itself fits, with at least one bit when LATENCY is 0.
  localparam int CNT_W = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX = LINE_ADDR_LEN'(LINE_SIZE - 1);

  logic [STATE_W-1:0]       state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  // Word offset is exactly LINE_ADDR_LEN wide, so it wraps instead of carrying into the line bits.
  logic [LINE_ADDR_LEN-1:0] idx_q, idx_d;
  logic [LINE_BITS-1:0]     line_q, line_d;
  logic [LINE_W-1:0]        data_q, data_d;
  logic                     is_wr_q, is_wr_d;
  logic [LINE_W-1:0]        rd_line_q, rd_line_d;
  // Read data returns one cycle after its address, so the capture slot trails idx by one cycle.
  logic                     cap_vld_q, cap_vld_d;
  logic [LINE_ADDR_LEN-1:0] cap_idx_q, cap_idx_d;

  // Next-state logic: acceptance, latency wait, burst sequencing and read-data capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    line_d    = line_q;
    data_d    = data_q;
    is_wr_d   = is_wr_q;
    rd_line_d = rd_line_q;
    cap_vld_d = (state_q == ST_XFER) && !is_wr_q;
    cap_idx_d = idx_q;

    if (cap_vld_q) begin
      rd_line_d[WORD_W*int'(cap_idx_q) +: WORD_W] = mem_rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_req || wr_req) begin
          line_d  = line_addr;
          data_d  = wr_line;
          is_wr_d = wr_req;
          cnt_d   = LAT_LOAD;
          idx_d   = '0;
          state_d = (LATENCY == 0) ? ST_XFER : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_XFER;
          idx_d   = '0;
        end
      end
      ST_XFER: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = is_wr_q ? ST_DONE : ST_TAIL;
        end
      end
      ST_TAIL: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      line_q    <= '0;
      data_q    <= '0;
      is_wr_q   <= 1'b0;
      rd_line_q <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      line_q    <= line_d;
      data_q    <= data_d;
      is_wr_q   <= is_wr_d;
      rd_line_q <= rd_line_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  // Memory-side outputs decoded from registered state; quiet outside the burst.
  always_comb begin
    mem_addr    = '0;
    mem_wr_req  = 1'b0;
    mem_wr_data = '0;
    if (state_q == ST_XFER) begin
      mem_addr = {line_q, idx_q};
      if (is_wr_q) begin
        mem_wr_req  = 1'b1;
        mem_wr_data = data_q[WORD_W*int'(idx_q) +: WORD_W];
      end
    end
  end

  assign rd_line = rd_line_q;
  assign gnt     = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Bench for mem_line_ctrl: two builds (LATENCY 4 and 0) each attached to a word memory.
// Latency: n/a.
// Backpressure: requests held until gnt, dropped on the edge that samples it.
module tb_mem_line_ctrl;

  localparam int LAT = 4;
  localparam int LS  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (LATENCY=4)
  logic         rd_req, wr_req;
  logic [7:0]   line_addr;
  logic [255:0] wr_line, rd_line;
  logic         gnt;
  logic [10:0]  mem_addr;
  logic         mem_wr_req;
  logic [31:0]  mem_wr_data, mem_rd_data;

  // Zero-latency instance
  logic         z_rd_req, z_wr_req;
  logic [7:0]   z_line_addr;
  logic [255:0] z_wr_line, z_rd_line;
  logic         z_gnt;
  logic [10:0]  z_mem_addr;
  logic         z_mem_wr_req;
  logic [31:0]  z_mem_wr_data, z_mem_rd_data;

  mem_line_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(11), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .line_addr(line_addr),
    .wr_line(wr_line), .rd_line(rd_line), .gnt(gnt), .mem_addr(mem_addr),
    .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  mem_line_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(11), .LATENCY(0)) u_dut_z (
    .clk(clk), .rst(rst), .rd_req(z_rd_req), .wr_req(z_wr_req), .line_addr(z_line_addr),
    .wr_line(z_wr_line), .rd_line(z_rd_line), .gnt(z_gnt), .mem_addr(z_mem_addr),
    .mem_wr_req(z_mem_wr_req), .mem_wr_data(z_mem_wr_data), .mem_rd_data(z_mem_rd_data)
  );

  // Word memories behind each instance, plus a preload port.
  logic        pl_en = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [31:0] pl_dat = '0;
  logic [31:0] mem_a [0:2047];
  logic [31:0] mem_b [0:2047];

  always @(posedge clk) begin
    if (pl_en) begin
      mem_a[pl_addr] <= pl_dat;
      mem_b[pl_addr] <= pl_dat;
    end else begin
      if (mem_wr_req)   mem_a[mem_addr]   <= mem_wr_data;
      if (z_mem_wr_req) mem_b[z_mem_addr] <= z_mem_wr_data;
    end
    mem_rd_data   <= mem_a[mem_addr];
    z_mem_rd_data <= mem_b[z_mem_addr];
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pre_val(input int a);
    if (a >= 16 && a < 24) return 32'hA0 + 32'(a - 16);
    return 32'h5EED_0000 ^ 32'(a * 40503);
  endfunction

  function automatic logic [255:0] seq_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < LS; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  // Transaction-level reference for the main instance: shadow memory plus op timeline.
  logic [31:0]  ref_mem [0:2047];
  bit           m_busy = 1'b0;
  int           m_cyc = 0;
  bit           m_wr = 1'b0;
  logic [7:0]   m_line = '0;
  logic [255:0] m_data = '0;
  logic [255:0] m_pend = '0;
  logic [255:0] exp_rd = '0;

  function automatic int done_cyc(input bit w);
    return w ? LAT + LS + 1 : LAT + LS + 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cyc  <= 0;
      exp_rd <= '0;
    end else if (pl_en) begin
      ref_mem[pl_addr] <= pl_dat;
    end else if (m_busy) begin
      if (m_wr && m_cyc >= LAT + 1 && m_cyc <= LAT + LS)
        ref_mem[int'(m_line)*LS + (m_cyc-LAT-1)] <= m_data[32*(m_cyc-LAT-1) +: 32];
      if (m_cyc == done_cyc(m_wr)) begin
        m_busy <= 1'b0;
        if (!m_wr) exp_rd <= m_pend;
      end else begin
        m_cyc <= m_cyc + 1;
      end
    end else if (rd_req || wr_req) begin
      m_busy <= 1'b1;
      m_cyc  <= 1;
      m_wr   <= wr_req;
      m_line <= line_addr;
      m_data <= wr_line;
      for (int i = 0; i < LS; i++) m_pend[32*i +: 32] <= ref_mem[int'(line_addr)*LS + i];
    end
  end

  // Every-cycle comparison of the main instance against the reference.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      logic [10:0] ea;
      logic        ew;
      logic [31:0] ed;
      logic        eg;
      int          ix;
      ea = '0; ew = 1'b0; ed = '0; ix = 0;
      if (m_busy && m_cyc >= LAT + 1 && m_cyc <= LAT + LS) begin
        ix = m_cyc - LAT - 1;
        ea = 11'(int'(m_line)*LS + ix);
        ew = m_wr;
        if (m_wr) ed = m_data[32*ix +: 32];
      end
      eg = m_busy && (m_cyc == done_cyc(m_wr));
      chk("cyc_mem_addr", mem_addr, ea);
      chk("cyc_mem_wr_req", mem_wr_req, ew);
      chk("cyc_mem_wr_data", mem_wr_data, ed);
      chk("cyc_gnt", gnt, eg);
      if (!m_busy || m_wr) chk("cyc_rd_line", rd_line, exp_rd);
      else if (eg) chk("cyc_rd_line_done", rd_line, m_pend);
    end
  end

  // Observations gathered by run_op.
  int          obs_wcnt, obs_first_n, obs_last_n, obs_nz;
  logic [10:0] obs_first, obs_last, obs_min, obs_max;

  // Issue one op; gcyc = cycle index of gnt counted from the first sampling cycle (-1 on timeout).
  task automatic run_op(input bit z, input int gap, input bit w, input bit r,
                        input logic [7:0] line, input logic [255:0] data,
                        input bit mutate, output int gcyc);
    logic        g, wq;
    logic [10:0] a;
    logic [255:0] junk;
    gcyc = -1;
    obs_wcnt = 0; obs_first_n = -1; obs_last_n = -1; obs_nz = 0;
    obs_first = '0; obs_last = '0; obs_min = '1; obs_max = '0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    if (z) begin
      z_wr_req = w; z_rd_req = r; z_line_addr = line; z_wr_line = data;
    end else begin
      wr_req = w; rd_req = r; line_addr = line; wr_line = data;
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      g  = z ? z_gnt : gnt;
      wq = z ? z_mem_wr_req : mem_wr_req;
      a  = z ? z_mem_addr : mem_addr;
      if (wq) begin
        if (obs_wcnt == 0) begin obs_first = a; obs_first_n = n; end
        obs_wcnt++;
        obs_last = a; obs_last_n = n;
      end
      if (a != 0) begin
        obs_nz++;
        if (a < obs_min) obs_min = a;
        if (a > obs_max) obs_max = a;
      end
      if (g) begin
        gcyc = n;
        break;
      end
      if (mutate && !z && n >= 1) begin
        line_addr = 8'($urandom);
        for (int i = 0; i < LS; i++) junk[32*i +: 32] = $urandom;
        wr_line = junk;
        if (w) rd_req = 1'($urandom);
      end
    end
    if (gcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout got=none want=gnt within 60 cycles t=%0t", $time);
    end
    @(posedge clk);
    #1;
    if (z) begin z_wr_req = 1'b0; z_rd_req = 1'b0; end
    else begin wr_req = 1'b0; rd_req = 1'b0; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bit found;
    int bad;
    int sel;
    int gap;
    bit rw, rr;
    logic [7:0] ln;
    logic [255:0] dat;

    rd_req = 0; wr_req = 0; line_addr = '0; wr_line = '0;
    z_rd_req = 0; z_wr_req = 0; z_line_addr = '0; z_wr_line = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_line", rd_line, '0);
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wr_req", mem_wr_req, 1'b0);
    chk("rst_mem_wr_data", mem_wr_data, '0);
    chk("rst_z_gnt", z_gnt, 1'b0);
    chk("rst_z_mem_wr_req", z_mem_wr_req, 1'b0);
    chk("rst_z_rd_line", z_rd_line, '0);
    rst = 1'b0;

    // Preload both memories
    for (int a = 0; a < 2048; a++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 11'(a); pl_dat = pre_val(a);
    end
    @(negedge clk);
    pl_en = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Read line 2 (preloaded 0xA0+i)
    run_op(0, 1, 0, 1, 8'h02, '0, 0, g);
    chk("rd2_gnt_cycle", g, 14);
    for (int i = 0; i < LS; i++) chk("rd2_word", rd_line[32*i +: 32], 32'hA0 + 32'(i));
    @(negedge clk);
    chk("rd2_gnt_one_cycle", gnt, 1'b0);

    // Write line 5 with address/data wiggled mid-op
    run_op(0, 1, 1, 0, 8'h05, seq_line(32'h1000), 1, g);
    chk("wr5_gnt_cycle", g, 13);
    chk("wr5_wcnt", obs_wcnt, 8);
    chk("wr5_first_addr", obs_first, 11'h028);
    chk("wr5_last_addr", obs_last, 11'h02F);
    chk("wr5_consecutive", obs_last_n - obs_first_n + 1, 8);
    chk("wr5_rd_line_kept", rd_line, seq_line(32'hA0));
    run_op(0, 2, 0, 1, 8'h05, '0, 1, g);
    chk("rd5_line", rd_line, seq_line(32'h1000));

    // Both requests high: write wins, rd_line untouched
    run_op(0, 0, 1, 1, 8'h06, seq_line(32'h3000), 1, g);
    chk("both_gnt_cycle", g, 13);
    chk("both_rd_line_kept", rd_line, seq_line(32'h1000));
    run_op(0, 0, 0, 1, 8'h06, '0, 0, g);
    chk("rd6_line", rd_line, seq_line(32'h3000));

    // Top line of the address space
    run_op(0, 1, 0, 1, 8'hFF, '0, 0, g);
    chk("rdff_gnt_cycle", g, 14);
    chk("rdff_access_cnt", obs_nz, 8);
    chk("rdff_min_addr", obs_min, 11'h7F8);
    chk("rdff_max_addr", obs_max, 11'h7FF);
    for (int i = 0; i < LS; i++) chk("rdff_word", rd_line[32*i +: 32], pre_val(2040 + i));

    // Reset during a write burst after three words
    @(posedge clk);
    #1;
    wr_req = 1'b1; line_addr = 8'h10; wr_line = seq_line(32'h5000);
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (mem_wr_req && mem_addr == 11'h083) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_reached_word3", found, 1'b1);
    #2;
    rst = 1'b1;
    wr_req = 1'b0;
    #1;
    chk("abort_wr_req_drop", mem_wr_req, 1'b0);
    chk("abort_mem_addr", mem_addr, '0);
    chk("abort_gnt", gnt, 1'b0);
    chk("abort_rd_line", rd_line, '0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < LS; i++)
      chk("abort_mem_word", mem_a[128 + i], (i < 3) ? 32'h5000 + 32'(i) : pre_val(128 + i));
    @(posedge clk);
    #1;
    run_op(0, 0, 0, 1, 8'h10, '0, 0, g);
    chk("post_abort_gnt_cycle", g, 14);
    for (int i = 0; i < LS; i++)
      chk("post_abort_word", rd_line[32*i +: 32], (i < 3) ? 32'h5000 + 32'(i) : pre_val(128 + i));

    // Zero-latency build
    run_op(1, 1, 1, 0, 8'h03, seq_line(32'h2000), 0, g);
    chk("z_wr_gnt_cycle", g, 9);
    chk("z_wr_wcnt", obs_wcnt, 8);
    chk("z_wr_first_addr", obs_first, 11'h018);
    run_op(1, 1, 0, 1, 8'h03, '0, 0, g);
    chk("z_rd_gnt_cycle", g, 10);
    chk("z_rd_line", z_rd_line, seq_line(32'h2000));
    run_op(1, 0, 0, 1, 8'h02, '0, 0, g);
    chk("z_rd2_line", z_rd_line, seq_line(32'hA0));

    // Randomized traffic on the main instance
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 2);
      rr = (sel != 1);
      rw = (sel != 0);
      ln = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      for (int i = 0; i < LS; i++) dat[32*i +: 32] = $urandom;
      gap = $urandom_range(0, 3);
      run_op(0, gap, rw, rr, ln, dat, 1, g);
      chk("rand_gnt_cycle", g, rw ? 13 : 14);
    end

    repeat (4) @(negedge clk);
    bad = 0;
    for (int a = 0; a < 2048; a++) if (mem_a[a] !== ref_mem[a]) bad++;
    chk("final_mem_image_mismatches", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
